// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ producers.
// Grants bursts of up to MAX_BURST beats and never offers a beat to a full FIFO.
module fifo_wr_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 64,
    parameter int CNT_W     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          ack,
    input  logic [CNT_W-1:0]          fifo_count,
    output logic                      fifo_wr_en,
    output logic [DATA_W-1:0]         fifo_din,
    output logic [N_REQ-1:0]          grant,
    output logic [$clog2(N_REQ)-1:0]  owner,
    output logic                      busy
);
    localparam int OW = $clog2(N_REQ);
    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    typedef enum logic {S_IDLE, S_GRANT} state_t;

    state_t              state_q, state_d;
    logic [OW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [OW-1:0]       owner_q, owner_d;
    logic [BW-1:0]       beat_cnt_q, beat_cnt_d;
    logic                fifo_wr_en_q, fifo_wr_en_d;
    logic [DATA_W-1:0]   fifo_din_q, fifo_din_d;

    logic [CNT_W:0]      occupancy;
    logic                space;
    logic                ack_any;
    logic                pick_found;
    logic [OW-1:0]       pick_idx;
    logic [OW-1:0]       owner_next_ptr;
    logic [DATA_W-1:0]   owner_data;

    // The beat issued this cycle is not yet visible in fifo_count, so count it here.
    assign occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, fifo_wr_en_q};
    assign space     = occupancy < (CNT_W+1)'(DEPTH);

    assign busy       = (state_q == S_GRANT);
    assign owner      = owner_q;
    assign fifo_wr_en = fifo_wr_en_q;
    assign fifo_din   = fifo_din_q;
    assign owner_data = req_data[owner_q*DATA_W +: DATA_W];
    assign ack_any    = |ack;
    assign owner_next_ptr = (owner_q == OW'(N_REQ-1)) ? '0 : owner_q + OW'(1);

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
            assign grant[gi] = busy && (owner_q == OW'(gi));
            assign ack[gi]   = grant[gi] && req[gi] && space;
        end
    endgenerate

    // First requester at or after rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        int idx;
        idx        = 0;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!pick_found && req[idx]) begin
                pick_found = 1'b1;
                pick_idx   = OW'(idx);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        owner_d      = owner_q;
        beat_cnt_d   = beat_cnt_q;
        fifo_wr_en_d = 1'b0;
        fifo_din_d   = fifo_din_q;
        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    owner_d    = pick_idx;
                    beat_cnt_d = '0;
                    state_d    = S_GRANT;
                end
            end
            S_GRANT: begin
                if (ack_any) begin
                    fifo_wr_en_d = 1'b1;
                    fifo_din_d   = owner_data;
                    beat_cnt_d   = beat_cnt_q + BW'(1);
                end
                // A stalled owner (req held, no space) keeps the grant indefinitely.
                if (!req[owner_q] || (ack_any && beat_cnt_q == BW'(MAX_BURST-1))) begin
                    state_d  = S_IDLE;
                    rr_ptr_d = owner_next_ptr;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            rr_ptr_q     <= '0;
            owner_q      <= '0;
            beat_cnt_q   <= '0;
            fifo_wr_en_q <= 1'b0;
            fifo_din_q   <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            owner_q      <= owner_d;
            beat_cnt_q   <= beat_cnt_d;
            fifo_wr_en_q <= fifo_wr_en_d;
            fifo_din_q   <= fifo_din_d;
        end
    end
endmodule
